// File: rtl/val_pkg.sv
// val_pkg: shared constants and state encoding for the value loader
package val_pkg;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
endpackage

// File: rtl/val_track.sv
// val_track: running-extremum register; IS_MAX selects max (1) or min (0) tracking
module val_track
    import val_pkg::*;
#(
    parameter bit IS_MAX = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_ind_rst,
    input  logic              i_clear,
    input  logic              i_first,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_index,
    output logic [DATA_W-1:0] o_value,
    output logic [ADDR_W-1:0] o_index
);
    localparam logic [DATA_W-1:0] INIT = {DATA_W{~IS_MAX}};

    logic [DATA_W-1:0] r_value;
    logic [ADDR_W-1:0] r_index;
    logic              w_take;

    assign w_take  = i_valid && (i_first || (IS_MAX ? i_data > r_value : i_data < r_value));
    assign o_value = r_value;
    assign o_index = r_index;

    // Hold the extremum; a strict compare keeps the earliest index on ties
    always_ff @(posedge i_clk or posedge i_ind_rst) begin
        if (i_ind_rst) begin
            r_value <= INIT;
            r_index <= '0;
        end else if (i_clear) begin
            r_value <= INIT;
            r_index <= '0;
        end else if (w_take) begin
            r_value <= i_data;
            r_index <= i_index;
        end
    end
endmodule

// File: rtl/val_load.sv
// val_load: serial loader into an 8x4 array with running max (and min when VAL_LOAD_MIN_EN is defined)
module val_load
    import val_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_ind_rst,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [DATA_W-1:0] o_max_value,
    output logic [ADDR_W-1:0] o_max_index
`ifdef VAL_LOAD_MIN_EN
    ,
    output logic [DATA_W-1:0] o_min_value,
    output logic [ADDR_W-1:0] o_min_index
`endif
);
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_count;
    logic              w_xfer;
    logic              w_first;

    assign w_xfer    = i_valid && (r_state == FILL) && !i_start;
    assign w_first   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[i_rd_addr];

    // State register
    always_ff @(posedge i_clk or posedge i_ind_rst) begin
        if (i_ind_rst) r_state <= IDLE;
        else           r_state <= w_next;
    end

    // Next state and state-decoded handshake/status outputs
    always_comb begin
        w_next  = r_state;
        o_ready = (r_state == FILL);
        o_full  = (r_state == FULL);
        if (i_start)
            w_next = FILL;
        else if (w_xfer && r_count == (ADDR_W+1)'(DEPTH-1))
            w_next = FULL;
    end

    // Fill counter; it stops at DEPTH because transfers end in FULL
    always_ff @(posedge i_clk or posedge i_ind_rst) begin
        if (i_ind_rst)   r_count <= '0;
        else if (i_start) r_count <= '0;
        else if (w_xfer)  r_count <= r_count + 1'b1;
    end

    // Storage array; start leaves old contents readable
    always_ff @(posedge i_clk or posedge i_ind_rst) begin
        if (i_ind_rst) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (w_xfer) begin
            r_mem[r_count[ADDR_W-1:0]] <= i_data;
        end
    end

    val_track #(.IS_MAX(1'b1)) u_max (
        .i_clk     (i_clk),
        .i_ind_rst (i_ind_rst),
        .i_clear   (i_start),
        .i_first   (w_first),
        .i_valid   (w_xfer),
        .i_data    (i_data),
        .i_index   (r_count[ADDR_W-1:0]),
        .o_value   (o_max_value),
        .o_index   (o_max_index)
    );

`ifdef VAL_LOAD_MIN_EN
    val_track #(.IS_MAX(1'b0)) u_min (
        .i_clk     (i_clk),
        .i_ind_rst (i_ind_rst),
        .i_clear   (i_start),
        .i_first   (w_first),
        .i_valid   (w_xfer),
        .i_data    (i_data),
        .i_index   (r_count[ADDR_W-1:0]),
        .o_value   (o_min_value),
        .o_index   (o_min_index)
    );
`endif
endmodule

// File: tb/tb_val_load.sv
// tb_val_load: directed stimulus against a fill-list model of val_load
module tb_val_load;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] data = '0;
    logic [2:0] rd_addr = '0;
    logic       ready, full;
    logic [3:0] count;
    logic [3:0] rd_data, max_v;
    logic [2:0] max_i;
`ifdef VAL_LOAD_MIN_EN
    logic [3:0] min_v;
    logic [2:0] min_i;
`endif

    int nchk = 0;
    int nerr = 0;

    val_load dut (
        .i_clk       (clk),
        .i_ind_rst   (rst),
        .i_start     (start),
        .i_valid     (valid),
        .i_data      (data),
        .o_ready     (ready),
        .o_full      (full),
        .o_count     (count),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_max_value (max_v),
        .o_max_index (max_i)
`ifdef VAL_LOAD_MIN_EN
        ,
        .o_min_value (min_v),
        .o_min_index (min_i)
`endif
    );

    always #5 clk = ~clk;

    // Model: the cells, how many were accepted since start, and whether a fill is open
    logic [3:0] m_mem [8];
    int         m_cnt;
    bit         m_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0;
            m_cnt <= 0;
            for (int i = 0; i < 8; i++) m_mem[i] <= '0;
        end else if (start) begin
            m_run <= 1'b1;
            m_cnt <= 0;
        end else if (m_run && m_cnt < 8 && valid) begin
            m_mem[m_cnt] <= data;
            m_cnt <= m_cnt + 1;
        end
    end

    // Extremum over the values accepted since start: {index, value}
    function automatic logic [6:0] ext(input bit is_max);
        logic [3:0] v = is_max ? 4'h0 : 4'hF;
        logic [2:0] x = '0;
        for (int i = 0; i < m_cnt; i++)
            if (i == 0 || (is_max ? m_mem[i] > v : m_mem[i] < v)) begin
                v = m_mem[i];
                x = 3'(i);
            end
        return {x, v};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle, mid-period: outputs against the model
    always @(negedge clk) begin
        logic [6:0] mx;
        mx = ext(1'b1);
        chk("ready", 8'(ready), 8'(m_run && m_cnt < 8));
        chk("full", 8'(full), 8'(m_run && m_cnt == 8));
        chk("count", 8'(count), 8'(m_cnt));
        chk("rd_data", 8'(rd_data), 8'(m_mem[rd_addr]));
        chk("max_value", 8'(max_v), 8'(mx[3:0]));
        chk("max_index", 8'(max_i), 8'(mx[6:4]));
`ifdef VAL_LOAD_MIN_EN
        mx = ext(1'b0);
        chk("min_value", 8'(min_v), 8'(mx[3:0]));
        chk("min_index", 8'(min_i), 8'(mx[6:4]));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] d);
        valid = 1'b1;
        data  = d;
        cyc();
    endtask

    int         s1 [8] = '{3, 9, 2, 9, 1, 7, 4, 8};
    logic [3:0] exp_rd;

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("idle_ready", 8'(ready), 8'd0);
        chk("idle_count", 8'(count), 8'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1 chk("idle_rd", 8'(rd_data), 8'd0);
        end
        send(4'd5);
        send(4'd5);
        valid = 1'b0;
        chk("idle_ignore", 8'(count), 8'd0);

        pulse_start();
        for (int i = 0; i < 8; i++) send(4'(s1[i]));
        valid = 1'b0;
        chk("fill_full", 8'(full), 8'd1);
        chk("fill_count", 8'(count), 8'd8);
        chk("fill_max", 8'(max_v), 8'd9);
        chk("fill_maxi", 8'(max_i), 8'd1);
`ifdef VAL_LOAD_MIN_EN
        chk("fill_min", 8'(min_v), 8'd1);
        chk("fill_mini", 8'(min_i), 8'd4);
`endif
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1 chk("fill_rd", 8'(rd_data), 8'(s1[a]));
        end
        send(4'hF);
        valid = 1'b0;
        chk("full_hold", 8'(count), 8'd8);

        pulse_start();
        repeat (3) send(4'd0);
        valid = 1'b0;
        chk("zero_max", 8'(max_v), 8'd0);
        chk("zero_maxi", 8'(max_i), 8'd0);
`ifdef VAL_LOAD_MIN_EN
        chk("zero_min", 8'(min_v), 8'd0);
        chk("zero_mini", 8'(min_i), 8'd0);
`endif

        pulse_start();
        for (int i = 1; i <= 4; i++) send(4'(i));
        chk("pre_abort_max", 8'(max_v), 8'd4);
        start = 1'b1;
        send(4'hF);
        start = 1'b0;
        valid = 1'b0;
        chk("abort_count", 8'(count), 8'd0);
        chk("abort_max", 8'(max_v), 8'd0);
        send(4'd5);
        send(4'd6);
        chk("refill_count", 8'(count), 8'd2);
        chk("refill_maxi", 8'(max_i), 8'd1);
        rd_addr = 3'd0;
        #1 chk("refill_rd0", 8'(rd_data), 8'd5);
        rd_addr = 3'd4;
        #1 chk("stale_rd4", 8'(rd_data), 8'd1);
        rd_addr = 3'd7;
        #1 chk("stale_rd7", 8'(rd_data), 8'd8);

        rd_addr = 3'd2;
        data = 4'hA;
        #1 chk("same_cycle_old", 8'(rd_data), 8'd3);
        cyc();
        valid = 1'b0;
        exp_rd = 4'hA;
        chk("next_cycle_new", 8'(rd_data), 8'(exp_rd));
        chk("new_max", 8'(max_v), 8'hA);
        chk("new_maxi", 8'(max_i), 8'd2);

        send(4'd1);
        send(4'd1);
        valid = 1'b0;
        chk("pre_rst_count", 8'(count), 8'd5);
        rst = 1'b1;
        #1;
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_ready", 8'(ready), 8'd0);
        chk("rst_max", 8'(max_v), 8'd0);
        chk("rst_rd", 8'(rd_data), 8'd0);
        cyc();
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1 chk("rst_rd_all", 8'(rd_data), 8'd0);
        end
        send(4'd7);
        valid = 1'b0;
        chk("post_rst_ignore", 8'(count), 8'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
